rep3_tx: RTL and testbench
==========================

Name: rep3_tx

Overview:
- Transmit side of the triple-redundancy repetition link.
- Accepts a parallel data word over a valid/ready handshake.
- Serialises the word LSB first, sending each bit REP consecutive times on a single line, tagged with a copy index.
- The receive side groups the REP copies per bit and decides each bit by majority. A per-word fault-injection control inverts one chosen copy so the downstream vote can be exercised.

Parameters:
- DATA_W, 8, width of the parallel input word (>=1).
- REP, 3, copies sent per bit (odd, >=3; the link protocol fixes 3).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- data_i  input  DATA_W  word to transmit.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block accepts a word this cycle.
- flip_en_i  input  1  sampled with the word: enable fault injection for this word.
- flip_copy_i  input  $clog2(REP)  sampled with the word: index of the copy to invert.
- tx_o  output  1  serial line bit.
- tx_valid_o  output  1  tx_o carries a valid copy this cycle.
- copy_o  output  $clog2(REP)  copy index of tx_o, 0..REP-1.
- sof_o  output  1  first copy of the first bit (bit 0, copy 0) of a word.
- done_o  output  1  one-cycle pulse with the last copy of the last bit.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values while rst_i is high and on the first cycle after:
  - tx_o=0, tx_valid_o=0, copy_o=0, sof_o=0, done_o=0.
  - State IDLE, all counters 0.
  - ready_o=0 while rst_i is high.
- Reset mid-word aborts the word immediately. No done_o is produced, and the next cycle is IDLE with all outputs at reset values.
- States:
  - IDLE: ready_o=1.
  - SEND: ready_o=1 only on the final cycle of the word (bit DATA_W-1, copy REP-1); otherwise 0.
- Transitions:
  - IDLE -> SEND on valid_i && ready_o. data_i, flip_en_i and flip_copy_i are captured at that edge.
  - SEND -> IDLE after the final copy if no new word was accepted.
  - SEND -> SEND (new word) if valid_i && ready_o on the final cycle. This gives back-to-back words with zero gap cycles.
- ready_o is combinational from state and counters. It must not depend on valid_i.
- Latency: a word accepted at edge N drives its first copy (tx_valid_o=1, sof_o=1) in the cycle after edge N. Each word occupies exactly DATA_W*REP consecutive cycles with tx_valid_o=1.
- Ordering:
  - Bit index b runs 0..DATA_W-1, LSB first.
  - For each b, copy_o runs 0..REP-1 while tx_o = word[b].
  - With flip_en set, tx_o = ~word[b] when copy_o==flip_copy; this applies to every bit of that word.
- flip_copy_i >= REP with flip_en_i=1: no copy matches, so the word is sent uncorrupted (not an error).
- Counters wrap:
  - copy counter: REP-1 -> 0, incrementing the bit counter.
  - bit counter: DATA_W-1 -> 0 at word end.
- done_o=1 coincides with the final copy (tx_valid_o=1, copy_o=REP-1, bit DATA_W-1).
- valid_i while ready_o=0 is held off. data_i is not sampled and the upstream must hold it.
- All outputs except ready_o are registered.

Decomposition:
- Package rep3_pkg holds:
  - REP_DEFAULT=3;
  - copy_idx_t = logic [$clog2(REP_DEFAULT)-1:0];
  - enum state_t {IDLE, SEND}.
- The copy and bit counters sit in a natural sub-module, rep_ctr. It takes REP and DATA_W, with inputs start and advance, and outputs copy idx, bit idx and last.

Test Plan:
- Reset: hold rst_i 3 cycles -> all outputs 0, ready_o=0. Release -> ready_o=1, tx_valid_o=0.
- Single word: data_i=8'hA5, flip_en_i=0 -> 24 valid cycles. tx_o stream is 1,1,1,0,0,0,1,1,1,0,0,0,0,0,0,1,1,1,0,0,0,1,1,1. sof_o only on cycle 1, done_o only on cycle 24. Majority decode = 8'hA5.
- Fault injection: data_i=8'h3C, flip_en_i=1, flip_copy_i=1 -> copy 1 of every bit is inverted (bit0 copies 0,1,0). Majority decode still yields 8'h3C.
- Back-to-back: valid_i held high with 8'h01 then 8'hFF -> ready_o=1 only on cycle 24 of the first word. Second sof_o on cycle 25, no gap. 48 contiguous valid cycles.
- Backpressure: valid_i asserted with 8'h55 during cycle 10 of a word -> not accepted until the final cycle. Data is held; the word is later sent intact.
- Reset mid-word: assert rst_i at bit 3, copy 1 -> next cycle tx_valid_o=0, no done_o. After release, a new word 8'h80 is sent from sof_o correctly.

Source files
------------

// File: rtl/rep3_pkg.sv
// Shared types and constants for the rep3 repetition-link transmitter.
// The link protocol fixes three copies per bit; REP_DEFAULT captures that.
package rep3_pkg;

   localparam int REP_DEFAULT = 3;

   typedef logic [$clog2(REP_DEFAULT)-1:0] copy_idx_t;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

endpackage

// File: rtl/rep_ctr.sv
// Copy/bit position counter for the repetition serialiser.
// copy_o/bit_o name the copy that goes on the line at the next advance; last_o flags the final copy.
module rep_ctr #(
   parameter int  REP    = 3,
   parameter int  DATA_W = 8,
   localparam int CW     = $clog2(REP),
   localparam int BW     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          advance_i,
   output logic [CW-1:0] copy_o,
   output logic [BW-1:0] bit_o,
   output logic          last_o
);

   localparam logic [CW-1:0] COPY_MAX = CW'(REP - 1);
   localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_W - 1);

   logic [CW-1:0] copy_q, copy_d, copy_base;
   logic [BW-1:0] bit_q, bit_d, bit_base;

   // start consumes copy 0 of a fresh word, so it steps from position zero.
   always_comb begin
      copy_base = start_i ? '0 : copy_q;
      bit_base  = start_i ? '0 : bit_q;
      copy_d    = copy_q;
      bit_d     = bit_q;
      if (start_i || advance_i) begin
         if (copy_base == COPY_MAX) begin
            copy_d = '0;
            bit_d  = (bit_base == BIT_MAX) ? '0 : bit_base + BW'(1);
         end else begin
            copy_d = copy_base + CW'(1);
            bit_d  = bit_base;
         end
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         copy_q <= '0;
         bit_q  <= '0;
      end else begin
         copy_q <= copy_d;
         bit_q  <= bit_d;
      end
   end

   assign copy_o = copy_q;
   assign bit_o  = bit_q;
   assign last_o = (copy_q == COPY_MAX) && (bit_q == BIT_MAX);

endmodule

// File: rtl/rep3_tx.sv
// Transmit side of the triple-redundancy link: serialises a word LSB first,
// each bit repeated REP times with a copy index, optionally inverting one copy.
module rep3_tx
   import rep3_pkg::*;
#(
   parameter int  DATA_W = 8,
   parameter int  REP    = REP_DEFAULT,
   localparam int CW     = $clog2(REP)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              flip_en_i,
   input  logic [CW-1:0]     flip_copy_i,
   output logic              tx_o,
   output logic              tx_valid_o,
   output logic [CW-1:0]     copy_o,
   output logic              sof_o,
   output logic              done_o
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              flip_en_q, flip_en_d;
   logic [CW-1:0]     flip_copy_q, flip_copy_d;

   logic              tx_q, tx_d;
   logic              tx_valid_q, tx_valid_d;
   logic [CW-1:0]     copy_q, copy_d;
   logic              sof_q, sof_d;
   logic              done_q, done_d;

   logic              accept;
   logic              ctr_start, ctr_advance, ctr_last;
   logic [CW-1:0]     ctr_copy;
   logic [BW-1:0]     ctr_bit;

   rep_ctr #(
      .REP    (REP),
      .DATA_W (DATA_W)
   ) u_ctr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (ctr_start),
      .advance_i (ctr_advance),
      .copy_o    (ctr_copy),
      .bit_o     (ctr_bit),
      .last_o    (ctr_last)
   );

   // done_q marks the final copy on the line, which is the only SEND cycle open to a new word.
   assign ready_o = !rst_i && ((state_q == IDLE) || ((state_q == SEND) && done_q));
   assign accept  = valid_i && ready_o;

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      flip_en_d   = flip_en_q;
      flip_copy_d = flip_copy_q;
      tx_d        = 1'b0;
      tx_valid_d  = 1'b0;
      copy_d      = '0;
      sof_d       = 1'b0;
      done_d      = 1'b0;
      ctr_start   = 1'b0;
      ctr_advance = 1'b0;

      if (accept) begin
         state_d     = SEND;
         word_d      = data_i;
         flip_en_d   = flip_en_i;
         flip_copy_d = flip_copy_i;
         ctr_start   = 1'b1;
         tx_valid_d  = 1'b1;
         sof_d       = 1'b1;
         tx_d        = data_i[0] ^ (flip_en_i && (flip_copy_i == '0));
      end else if (state_q == SEND) begin
         if (done_q) begin
            state_d = IDLE;
         end else begin
            ctr_advance = 1'b1;
            tx_valid_d  = 1'b1;
            copy_d      = ctr_copy;
            done_d      = ctr_last;
            tx_d        = word_q[ctr_bit] ^ (flip_en_q && (flip_copy_q == ctr_copy));
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         word_q      <= '0;
         flip_en_q   <= 1'b0;
         flip_copy_q <= '0;
         tx_q        <= 1'b0;
         tx_valid_q  <= 1'b0;
         copy_q      <= '0;
         sof_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         flip_en_q   <= flip_en_d;
         flip_copy_q <= flip_copy_d;
         tx_q        <= tx_d;
         tx_valid_q  <= tx_valid_d;
         copy_q      <= copy_d;
         sof_q       <= sof_d;
         done_q      <= done_d;
      end
   end

   assign tx_o       = tx_q;
   assign tx_valid_o = tx_valid_q;
   assign copy_o     = copy_q;
   assign sof_o      = sof_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_rep3_tx.sv
// Self-checking bench for rep3_tx: per-copy scoreboard, majority decoder and vector table.
module tb_rep3_tx;
   import rep3_pkg::*;

   localparam int DATA_W = 8;
   localparam int REP    = 3;
   localparam int CW     = $clog2(REP);
   localparam int NCOPY  = DATA_W * REP;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [DATA_W-1:0] data_i;
   logic              valid_i;
   logic              ready_o;
   logic              flip_en_i;
   logic [CW-1:0]     flip_copy_i;
   logic              tx_o;
   logic              tx_valid_o;
   logic [CW-1:0]     copy_o;
   logic              sof_o;
   logic              done_o;

   rep3_tx #(
      .DATA_W (DATA_W),
      .REP    (REP)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .flip_en_i   (flip_en_i),
      .flip_copy_i (flip_copy_i),
      .tx_o        (tx_o),
      .tx_valid_o  (tx_valid_o),
      .copy_o      (copy_o),
      .sof_o       (sof_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          tx;
      logic [CW-1:0] copy;
      logic          sof;
      logic          done;
   } exp_copy_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              flip_en;
      copy_idx_t         flip_copy;
      logic [NCOPY-1:0]  exp_stream;
      logic [DATA_W-1:0] exp_word;
   } vec_t;

   exp_copy_t         exp_q[$];
   logic [DATA_W-1:0] word_exp_q[$];
   exp_copy_t         mon_e;

   int n_checks = 0;
   int n_errors = 0;

   int                dec_copy = 0, dec_bit = 0, votes = 0;
   int                run_len = 0, last_run = 0, words_done = 0;
   logic [DATA_W-1:0] dec_word = '0, last_dec = '0;
   logic [NCOPY-1:0]  stream = '0, last_stream = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got unexpected event or timeout, expected none", name);
   endtask

   // Output monitor: scoreboard pop, majority vote, stream capture, run length; then push on accept.
   always @(negedge clk_i) begin
      if (tx_valid_o === 1'b1) begin
         run_len++;
         if (exp_q.size() == 0) begin
            fail_now("spurious_valid");
         end else begin
            mon_e = exp_q.pop_front();
            check("copy_stream", 32'({tx_o, copy_o, sof_o, done_o}),
                  32'({mon_e.tx, mon_e.copy, mon_e.sof, mon_e.done}));
         end
         if (sof_o) begin
            dec_copy = 0;
            dec_bit  = 0;
            dec_word = '0;
            stream   = '0;
         end
         if (dec_copy == 0) votes = 0;
         votes += int'(tx_o);
         stream = {stream[NCOPY-2:0], tx_o};
         if (dec_copy == REP - 1) begin
            if (dec_bit < DATA_W) dec_word[dec_bit] = (votes > REP / 2);
            dec_copy = 0;
            dec_bit++;
         end else begin
            dec_copy++;
         end
         if (done_o) begin
            last_dec    = dec_word;
            last_stream = stream;
            words_done++;
            if (word_exp_q.size() == 0) fail_now("spurious_done");
            else check("majority", 32'(dec_word), 32'(word_exp_q.pop_front()));
         end
      end else begin
         if (run_len > 0) last_run = run_len;
         run_len = 0;
         if ((sof_o === 1'b1) || (done_o === 1'b1)) check("strobe_idle", 32'({sof_o, done_o}), 32'd0);
      end

      if (rst_i === 1'b1) begin
         exp_q.delete();
         word_exp_q.delete();
         dec_copy = 0;
         dec_bit  = 0;
      end else if ((valid_i === 1'b1) && (ready_o === 1'b1)) begin
         for (int b = 0; b < DATA_W; b++) begin
            for (int c = 0; c < REP; c++) begin
               exp_copy_t e;
               e.tx   = data_i[b] ^ (flip_en_i && (flip_copy_i == CW'(c)));
               e.copy = CW'(c);
               e.sof  = (b == 0) && (c == 0);
               e.done = (b == DATA_W - 1) && (c == REP - 1);
               exp_q.push_back(e);
            end
         end
         word_exp_q.push_back(data_i);
      end
   end

   task automatic send_word(input logic [DATA_W-1:0] d, input logic fe, input logic [CW-1:0] fc,
                            output int waited);
      bit acc;
      acc    = 1'b0;
      waited = 0;
      data_i      = d;
      flip_en_i   = fe;
      flip_copy_i = fc;
      valid_i     = 1'b1;
      while (!acc && waited < 100) begin
         @(negedge clk_i);
         waited++;
         acc = (ready_o === 1'b1);
         @(posedge clk_i);
         #1;
      end
      valid_i = 1'b0;
      if (!acc) fail_now("accept_timeout");
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tx_valid_o === 1'b1) && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 200) fail_now("idle_timeout");
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[7];
      int   w;
      int   wd;

      vecs[0] = '{8'hA5, 1'b0, 2'd0, 24'hE381C7, 8'hA5};
      vecs[1] = '{8'h3C, 1'b1, 2'd1, 24'h4ADB52, 8'h3C};
      vecs[2] = '{8'h00, 1'b1, 2'd0, 24'h924924, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 2'd2, 24'hDB6DB6, 8'hFF};
      vecs[4] = '{8'h5A, 1'b1, 2'd3, 24'h1C7E38, 8'h5A};
      vecs[5] = '{8'h01, 1'b0, 2'd2, 24'hE00000, 8'h01};
      vecs[6] = '{8'h80, 1'b1, 2'd0, 24'h924923, 8'h80};

      rst_i       = 1'b1;
      valid_i     = 1'b0;
      data_i      = '0;
      flip_en_i   = 1'b0;
      flip_copy_i = '0;

      // Reset held for three edges.
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_outputs", 32'({tx_o, tx_valid_o, copy_o, sof_o, done_o}), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_ready", 32'(ready_o), 32'd1);
      check("post_rst_valid", 32'(tx_valid_o), 32'd0);
      @(posedge clk_i);
      #1;

      // Table of single words: serial stream, majority decode, word length.
      for (int i = 0; i < 7; i++) begin
         send_word(vecs[i].data, vecs[i].flip_en, vecs[i].flip_copy, w);
         wait_idle();
         check($sformatf("tbl%0d_stream", i), 32'(last_stream), 32'(vecs[i].exp_stream));
         check($sformatf("tbl%0d_word", i), 32'(last_dec), 32'(vecs[i].exp_word));
         check($sformatf("tbl%0d_len", i), 32'(last_run), 32'(NCOPY));
      end

      // Back-to-back: valid held across two words.
      send_word(8'h01, 1'b0, 2'd0, w);
      send_word(8'hFF, 1'b0, 2'd0, w);
      check("b2b_ready_cycle", 32'(w), 32'(NCOPY));
      wait_idle();
      check("b2b_run", 32'(last_run), 32'(2 * NCOPY));
      check("b2b_word", 32'(last_dec), 32'hFF);

      // Backpressure: second word offered in cycle 10 of the first.
      send_word(8'hC3, 1'b1, 2'd2, w);
      repeat (9) @(posedge clk_i);
      #1;
      send_word(8'h55, 1'b0, 2'd0, w);
      check("bp_wait", 32'(w), 32'(NCOPY - 9));
      wait_idle();
      check("bp_word", 32'(last_dec), 32'h55);
      check("bp_run", 32'(last_run), 32'(2 * NCOPY));

      // Reset mid-word at bit 3, copy 1.
      send_word(8'hC6, 1'b0, 2'd0, w);
      repeat (10) @(posedge clk_i);
      #1;
      check("mid_copy", 32'(copy_o), 32'd1);
      wd    = words_done;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("abort_outputs", 32'({tx_o, tx_valid_o, copy_o, sof_o, done_o}), 32'd0);
      check("abort_ready", 32'(ready_o), 32'd0);
      rst_i = 1'b0;
      #1;
      check("abort_ready_rel", 32'(ready_o), 32'd1);
      repeat (3) @(posedge clk_i);
      #1;
      check("abort_no_done", 32'(words_done), 32'(wd));
      check("abort_idle", 32'(tx_valid_o), 32'd0);
      send_word(8'h80, 1'b0, 2'd0, w);
      wait_idle();
      check("abort_next_word", 32'(last_dec), 32'h80);
      check("abort_next_stream", 32'(last_stream), 32'h000007);
      check("abort_next_count", 32'(words_done), 32'(wd + 1));

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
